// File: rtl/hv_abist_rsp.sv
// Digital stand-in for the HV analog BIST macro: answers each abist stimulus with a
// delayed fault flag (ch0..4) or periodic ADC conversions (ch5), with per-channel fault injection.
module hv_abist_rsp #(
  parameter int unsigned       ADC_DW       = 10,
  parameter int unsigned       CLK_M        = 48,
  parameter int unsigned       DLY_W        = 8,
  parameter int unsigned       ADC_CONV_CYC = 4 * CLK_M,
  parameter logic [ADC_DW-1:0] ADC_CODE1    = ADC_DW'(10'h200),
  parameter logic [ADC_DW-1:0] ADC_CODE2    = ADC_DW'(10'h203),
  parameter logic [ADC_DW-1:0] ADC_BAD_CODE = ADC_DW'(10'h000)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [5:0]        i_stim,
  input  logic [DLY_W-1:0]  i_asrt_dly,
  input  logic [DLY_W-1:0]  i_rls_dly,
  input  logic [5:0]        i_inj_en,
  input  logic [5:0]        i_inj_mode,
  output logic              o_hv_vcc_ov,
  output logic              o_hv_ot,
  output logic              o_hv_desat_flt,
  output logic              o_hv_oc,
  output logic              o_hv_scp_flt,
  output logic              o_hv_adc_rdy1,
  output logic [ADC_DW-1:0] o_hv_adc_data1,
  output logic              o_hv_adc_rdy2,
  output logic [ADC_DW-1:0] o_hv_adc_data2
);

  localparam int unsigned NCH      = 6;
  localparam int unsigned NFLG     = 5;
  localparam int unsigned ADC_CH   = 5;
  localparam int unsigned CNV_W    = (ADC_CONV_CYC > 1) ? $clog2(ADC_CONV_CYC) : 1;
  localparam logic [CNV_W-1:0] CNV_LAST = CNV_W'(ADC_CONV_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADLY = 2'd1,
    ST_ACT  = 2'd2,
    ST_RDLY = 2'd3
  } state_e;

  state_e             state_q [NCH];
  state_e             state_d [NCH];
  logic [DLY_W-1:0]   cnt_q   [NCH];
  logic [DLY_W-1:0]   cnt_d   [NCH];
  logic [NFLG-1:0]    flag_q, flag_d;
  logic [CNV_W-1:0]   conv_cnt_q, conv_cnt_d;
  logic [CNV_W-1:0]   inj_cnt_q, inj_cnt_d;
  logic               rdy_q, rdy_d;
  logic [ADC_DW-1:0]  data1_q, data1_d;
  logic [ADC_DW-1:0]  data2_q, data2_d;

  // Per-channel handshake FSM: assert delay, active, release delay.
  always_comb begin
    for (int unsigned i = 0; i < NCH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      if (i_inj_en[i]) begin
        state_d[i] = ST_IDLE;
        cnt_d[i]   = '0;
      end else begin
        case (state_q[i])
          ST_IDLE: begin
            if (i_stim[i]) begin
              state_d[i] = ST_ADLY;
              cnt_d[i]   = '0;
            end
          end
          ST_ADLY: begin
            if (!i_stim[i]) begin
              state_d[i] = ST_IDLE;
              cnt_d[i]   = '0;
            end else if (cnt_q[i] == i_asrt_dly) begin
              state_d[i] = ST_ACT;
              cnt_d[i]   = '0;
            end else begin
              cnt_d[i] = cnt_q[i] + DLY_W'(1);
            end
          end
          ST_ACT: begin
            if (!i_stim[i]) begin
              state_d[i] = ST_RDLY;
              cnt_d[i]   = '0;
            end
          end
          ST_RDLY: begin
            // Re-assertion of the stimulus is ignored until IDLE is reached.
            if (cnt_q[i] == i_rls_dly) begin
              state_d[i] = ST_IDLE;
              cnt_d[i]   = '0;
            end else begin
              cnt_d[i] = cnt_q[i] + DLY_W'(1);
            end
          end
          default: begin
            state_d[i] = ST_IDLE;
            cnt_d[i]   = '0;
          end
        endcase
      end
    end
  end

  // Flag outputs follow the next FSM state unless injection overrides them.
  always_comb begin
    flag_d = '0;
    for (int unsigned i = 0; i < NFLG; i++) begin
      if (i_inj_en[i]) begin
        flag_d[i] = i_inj_mode[i];
      end else begin
        flag_d[i] = (state_d[i] == ST_ACT) || (state_d[i] == ST_RDLY);
      end
    end
  end

  // ADC conversion cadence; stuck injection runs its own cadence off the raw stimulus.
  always_comb begin
    rdy_d      = 1'b0;
    data1_d    = data1_q;
    data2_d    = data2_q;
    conv_cnt_d = '0;
    inj_cnt_d  = '0;
    if (i_inj_en[ADC_CH]) begin
      if (i_inj_mode[ADC_CH] && i_stim[ADC_CH]) begin
        if (inj_cnt_q == CNV_LAST) begin
          rdy_d   = 1'b1;
          data1_d = ADC_BAD_CODE;
          data2_d = ADC_CODE2;
        end else begin
          inj_cnt_d = inj_cnt_q + CNV_W'(1);
        end
      end
    end else if (state_q[ADC_CH] == ST_ACT && i_stim[ADC_CH]) begin
      if (conv_cnt_q == CNV_LAST) begin
        rdy_d   = 1'b1;
        data1_d = ADC_CODE1;
        data2_d = ADC_CODE2;
      end else begin
        conv_cnt_d = conv_cnt_q + CNV_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        state_q[i] <= ST_IDLE;
        cnt_q[i]   <= '0;
      end
      flag_q     <= '0;
      conv_cnt_q <= '0;
      inj_cnt_q  <= '0;
      rdy_q      <= 1'b0;
      data1_q    <= '0;
      data2_q    <= '0;
    end else begin
      for (int unsigned i = 0; i < NCH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      flag_q     <= flag_d;
      conv_cnt_q <= conv_cnt_d;
      inj_cnt_q  <= inj_cnt_d;
      rdy_q      <= rdy_d;
      data1_q    <= data1_d;
      data2_q    <= data2_d;
    end
  end

  assign o_hv_vcc_ov    = flag_q[0];
  assign o_hv_ot        = flag_q[1];
  assign o_hv_desat_flt = flag_q[2];
  assign o_hv_oc        = flag_q[3];
  assign o_hv_scp_flt   = flag_q[4];
  assign o_hv_adc_rdy1  = rdy_q;
  assign o_hv_adc_rdy2  = rdy_q;
  assign o_hv_adc_data1 = data1_q;
  assign o_hv_adc_data2 = data2_q;

endmodule

// File: tb/tb_hv_abist_rsp.sv
// Bench for hv_abist_rsp: directed scenarios plus randomized traffic against a
// timestamp-based reference model of the abist responder.
module tb_hv_abist_rsp;

  localparam int CONV = 192;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] stim, inj_en, inj_mode;
  logic [7:0] asrt, rls;
  logic       vcc_ov, ot, desat, oc, scp, rdy1, rdy2;
  logic [9:0] d1, d2;
  logic [4:0] flags;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  assign flags = {scp, oc, desat, ot, vcc_ov};

  hv_abist_rsp #(
    .ADC_DW(10), .CLK_M(48), .DLY_W(8), .ADC_CONV_CYC(CONV),
    .ADC_CODE1(10'h200), .ADC_CODE2(10'h203), .ADC_BAD_CODE(10'h000)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_stim(stim), .i_asrt_dly(asrt), .i_rls_dly(rls),
    .i_inj_en(inj_en), .i_inj_mode(inj_mode),
    .o_hv_vcc_ov(vcc_ov), .o_hv_ot(ot), .o_hv_desat_flt(desat), .o_hv_oc(oc),
    .o_hv_scp_flt(scp), .o_hv_adc_rdy1(rdy1), .o_hv_adc_data1(d1),
    .o_hv_adc_rdy2(rdy2), .o_hv_adc_data2(d2)
  );

  // Reference model: tracks absolute edge times of pending rise/fall events.
  int         cyc = 0;
  int         rise_t [6];
  int         fall_t [6];
  bit         on_m   [6];
  int         act_t;
  int         inj_run;
  logic [4:0] exp_flag;
  logic       exp_rdy;
  logic [9:0] exp_d1, exp_d2;

  always @(posedge clk) begin : model
    bit adc_act;
    cyc = cyc + 1;
    if (rst) begin
      for (int c = 0; c < 6; c++) begin
        rise_t[c] = -1; fall_t[c] = -1; on_m[c] = 1'b0;
      end
      act_t = 0; inj_run = 0;
      exp_flag = '0; exp_rdy = 1'b0; exp_d1 = '0; exp_d2 = '0;
    end else begin
      exp_rdy = 1'b0;
      adc_act = on_m[5] && (fall_t[5] < 0);
      if (inj_en[5]) begin
        if (inj_mode[5] && stim[5]) begin
          inj_run = inj_run + 1;
          if (inj_run % CONV == 0) begin
            exp_rdy = 1'b1; exp_d1 = 10'h000; exp_d2 = 10'h203;
          end
        end else begin
          inj_run = 0;
        end
      end else begin
        inj_run = 0;
        if (adc_act && stim[5] && ((cyc - act_t) % CONV == 0)) begin
          exp_rdy = 1'b1; exp_d1 = 10'h200; exp_d2 = 10'h203;
        end
      end
      for (int c = 0; c < 6; c++) begin
        if (inj_en[c]) begin
          rise_t[c] = -1; fall_t[c] = -1; on_m[c] = 1'b0;
        end else if (fall_t[c] >= 0) begin
          if (cyc == fall_t[c]) begin
            fall_t[c] = -1; on_m[c] = 1'b0;
          end
        end else if (on_m[c]) begin
          if (!stim[c]) fall_t[c] = cyc + int'(rls) + 1;
        end else if (rise_t[c] >= 0) begin
          if (!stim[c]) rise_t[c] = -1;
          else if (cyc == rise_t[c]) begin
            rise_t[c] = -1; on_m[c] = 1'b1;
            if (c == 5) act_t = cyc;
          end
        end else if (stim[c]) begin
          rise_t[c] = cyc + int'(asrt) + 1;
        end
      end
      for (int c = 0; c < 5; c++) exp_flag[c] = inj_en[c] ? inj_mode[c] : on_m[c];
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; stim = '0; inj_en = '0; inj_mode = '0;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    stim = 6'($urandom); inj_en = 6'($urandom); inj_mode = 6'($urandom);
    asrt = 8'd0; rls = 8'd0;
    step(); step();
    n_tests++; if (flags !== 5'b0) begin n_fail++; $display("FAIL reset_flags got %b want 00000", flags); end
    n_tests++; if (rdy1 !== 1'b0 || rdy2 !== 1'b0) begin n_fail++; $display("FAIL reset_rdy got %b%b want 00", rdy1, rdy2); end
    n_tests++; if (d1 !== 10'h0) begin n_fail++; $display("FAIL reset_data1 got %h want 000", d1); end
    n_tests++; if (d2 !== 10'h0) begin n_fail++; $display("FAIL reset_data2 got %h want 000", d2); end
    rst = 1'b0; stim = '0; inj_en = '0; inj_mode = '0;
  endtask

  task automatic test_assert_release();
    int t0, e, rise_e, fall_e;
    logic ex;
    do_reset();
    asrt = 8'd3; rls = 8'd2;
    stim[1] = 1'b1; t0 = cyc + 1; rise_e = -1; fall_e = -1;
    for (int k = 0; k < 20; k++) begin
      step(); e = cyc;
      ex = (e >= t0 + 4) && (e < t0 + 13);
      n_tests++; if (ot !== ex) begin n_fail++; $display("FAIL asrt_rls_ot edge=t0+%0d got %b want %b", e - t0, ot, ex); end
      if (ot === 1'b1 && rise_e < 0) rise_e = e;
      if (ot === 1'b0 && rise_e >= 0 && fall_e < 0) fall_e = e;
      if (e == t0 + 9) stim[1] = 1'b0;
    end
    n_tests++; if (rise_e != t0 + 4) begin n_fail++; $display("FAIL asrt_rise_edge got t0+%0d want t0+4", rise_e - t0); end
    n_tests++; if (fall_e != t0 + 13) begin n_fail++; $display("FAIL rls_fall_edge got t0+%0d want t0+13", fall_e - t0); end
  endtask

  task automatic test_abort();
    int t1, e;
    do_reset();
    asrt = 8'd5; rls = 8'd0;
    stim[0] = 1'b1;
    step(); step(); step();
    stim[0] = 1'b0;
    for (int k = 0; k < 12; k++) begin
      step();
      n_tests++; if (vcc_ov !== 1'b0) begin n_fail++; $display("FAIL abort_ov k=%0d got %b want 0", k, vcc_ov); end
    end
    stim[0] = 1'b1; t1 = cyc + 1;
    for (int k = 0; k < 8; k++) begin
      step(); e = cyc;
      n_tests++; if (vcc_ov !== (e >= t1 + 6)) begin n_fail++; $display("FAIL abort_restart edge=t1+%0d got %b want %b", e - t1, vcc_ov, e >= t1 + 6); end
    end
    stim[0] = 1'b0;
  endtask

  task automatic test_adc();
    int t0, e, npulse;
    logic ex;
    do_reset();
    asrt = 8'd0; rls = 8'd1;
    stim[5] = 1'b1; t0 = cyc + 1; npulse = 0;
    for (int k = 0; k < 620; k++) begin
      step(); e = cyc;
      ex = (e > t0 + 1) && (e < t0 + 600) && ((e - t0 - 1) % CONV == 0);
      n_tests++; if (rdy1 !== ex || rdy2 !== ex) begin n_fail++; $display("FAIL adc_rdy edge=t0+%0d got %b%b want %b", e - t0, rdy1, rdy2, ex); end
      if (ex) begin
        npulse++;
        n_tests++; if (d1 !== 10'h200 || d2 !== 10'h203) begin n_fail++; $display("FAIL adc_data got %h/%h want 200/203", d1, d2); end
      end
      if (e == t0 + 599) stim[5] = 1'b0;
    end
    n_tests++; if (npulse != 3) begin n_fail++; $display("FAIL adc_pulse_count got %0d want 3", npulse); end
    n_tests++; if (d1 !== 10'h200 || d2 !== 10'h203) begin n_fail++; $display("FAIL adc_data_hold got %h/%h want 200/203", d1, d2); end
  endtask

  task automatic test_inject();
    int npulse;
    do_reset();
    asrt = 8'd2; rls = 8'd2;
    inj_en = 6'b000100; inj_mode = 6'b000000; stim[2] = 1'b1;
    for (int k = 0; k < 100; k++) begin
      step();
      n_tests++; if (desat !== 1'b0) begin n_fail++; $display("FAIL inj0_desat k=%0d got %b want 0", k, desat); end
    end
    stim[2] = 1'b0; inj_en = '0;
    step();
    inj_en = 6'b001000; inj_mode = 6'b001000;
    step();
    n_tests++; if (oc !== 1'b1) begin n_fail++; $display("FAIL inj1_oc_immediate got %b want 1", oc); end
    for (int k = 0; k < 20; k++) begin
      stim[3] = 1'($urandom);
      step();
      n_tests++; if (oc !== 1'b1) begin n_fail++; $display("FAIL inj1_oc_held k=%0d got %b want 1", k, oc); end
    end
    inj_en = '0; inj_mode = '0; stim[3] = 1'b0;
    step();
    n_tests++; if (oc !== 1'b0) begin n_fail++; $display("FAIL inj_off_oc got %b want 0", oc); end
    inj_en = 6'b100000; inj_mode = 6'b100000; stim[5] = 1'b1; npulse = 0;
    for (int k = 0; k < 400; k++) begin
      step();
      n_tests++; if (rdy1 !== exp_rdy || rdy2 !== exp_rdy) begin n_fail++; $display("FAIL inj_adc_rdy k=%0d got %b%b want %b", k, rdy1, rdy2, exp_rdy); end
      if (rdy1 === 1'b1) begin
        npulse++;
        n_tests++; if (d1 !== 10'h000 || d2 !== 10'h203) begin n_fail++; $display("FAIL inj_adc_data got %h/%h want 000/203", d1, d2); end
      end
    end
    n_tests++; if (npulse != 2) begin n_fail++; $display("FAIL inj_adc_count got %0d want 2", npulse); end
    inj_en = '0; inj_mode = '0; stim[5] = 1'b0;
  endtask

  task automatic test_reset_mid();
    int t, e;
    do_reset();
    asrt = 8'd2; rls = 8'd5;
    stim[4] = 1'b1;
    repeat (5) step();
    n_tests++; if (scp !== 1'b1) begin n_fail++; $display("FAIL rstmid_act got %b want 1", scp); end
    rst = 1'b1;
    step();
    n_tests++; if (scp !== 1'b0) begin n_fail++; $display("FAIL rstmid_drop got %b want 0", scp); end
    rst = 1'b0; t = cyc + 1;
    for (int k = 0; k < 5; k++) begin
      step(); e = cyc;
      n_tests++; if (scp !== (e >= t + 3)) begin n_fail++; $display("FAIL rstmid_reassert edge=t+%0d got %b want %b", e - t, scp, e >= t + 3); end
    end
    stim[4] = 1'b0;
  endtask

  task automatic test_all_channels();
    int t0, e;
    do_reset();
    asrt = 8'd1; rls = 8'd1;
    stim = 6'h3f; t0 = cyc + 1;
    for (int k = 0; k < 200; k++) begin
      step(); e = cyc;
      n_tests++; if (flags !== ((e >= t0 + 2) ? 5'h1f : 5'h00)) begin n_fail++; $display("FAIL all_flags edge=t0+%0d got %b", e - t0, flags); end
      n_tests++; if (rdy1 !== (e == t0 + 2 + CONV)) begin n_fail++; $display("FAIL all_adc_rdy edge=t0+%0d got %b want %b", e - t0, rdy1, e == t0 + 2 + CONV); end
    end
    stim = '0;
  endtask

  task automatic test_random();
    int unsigned ch;
    for (int seg = 0; seg < 6; seg++) begin
      do_reset();
      asrt = 8'($urandom_range(0, 12)); rls = 8'($urandom_range(0, 12));
      stim[5] = 1'b1;
      for (int c = 0; c < 500; c++) begin
        for (int i = 0; i < 5; i++) if ($urandom_range(0, 7) == 0) stim[i] = ~stim[i];
        if ($urandom_range(0, 299) == 0) stim[5] = ~stim[5];
        if ($urandom_range(0, 79) == 0) begin
          ch = $urandom_range(0, 5);
          inj_en[ch] = ~inj_en[ch]; inj_mode[ch] = 1'($urandom);
        end
        step();
        n_tests++; if (flags !== exp_flag) begin n_fail++; $display("FAIL rand_flags seg=%0d c=%0d got %b want %b", seg, c, flags, exp_flag); end
        n_tests++; if (rdy1 !== exp_rdy || rdy2 !== exp_rdy) begin n_fail++; $display("FAIL rand_rdy seg=%0d c=%0d got %b%b want %b", seg, c, rdy1, rdy2, exp_rdy); end
        n_tests++; if (d1 !== exp_d1 || d2 !== exp_d2) begin n_fail++; $display("FAIL rand_data seg=%0d c=%0d got %h/%h want %h/%h", seg, c, d1, d2, exp_d1, exp_d2); end
      end
    end
  endtask

  initial begin
    rst = 1'b1; stim = '0; inj_en = '0; inj_mode = '0; asrt = '0; rls = '0;
    @(negedge clk);
    test_reset();
    test_assert_release();
    test_abort();
    test_adc();
    test_inject();
    test_reset_mid();
    test_all_channels();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
